mfp_ahb_lite_byte_stream_sink: RTL and testbench
================================================

// Module: mfp_ahb_lite_byte_stream_sink
// PURPOSE
//  AHB-lite slave that turns CPU stores into a byte stream for a downstream consumer (e.g. UART TX).
//  Byte-wide counterpart of the SREC-loader master: it receives the same HSIZE_1 / HSIZE_4 write
//  traffic and serialises it, instead of generating it. Bytes are buffered in a FIFO.
//  Sits on an AHB-lite decoder slot; a byte consumer drains its out_* port.
// PARAMETERS
//  FIFO_DEPTH_LOG2  4  log2 of FIFO entries (default 16 bytes); level field width FIFO_DEPTH_LOG2+1
// PORTS
//  clock       in   1   single clock for all logic
//  reset       in   1   synchronous, active-high reset
//  big_endian  in   1   1: lane/byte order big-endian; 0: little-endian
//  HSEL        in   1   slave select
//  HADDR       in   32  address; only [3:0] decoded
//  HTRANS      in   2   transfer type
//  HSIZE       in   3   transfer size
//  HWRITE      in   1   1=write
//  HWDATA      in   32  write data (data phase)
//  HREADY      in   1   bus ready (from mux)
//  HRDATA      out  32  read data
//  HREADYOUT   out  1   0 inserts wait states
//  HRESP       out  1   tied OKAY (0)
//  out_byte    out  8   FIFO head byte
//  out_valid   out  1   head valid (FIFO not empty)
//  out_ready   in   1   consumer accepts head when out_valid&&out_ready
// BEHAVIOUR
//  Clocking: one clock; reset is synchronous and active-high.
//  Reset: FIFO level 0, out_valid 0, out_byte 0, HREADYOUT 1, HRDATA 0, HRESP 0, state IDLE, address phase cleared.
//  Reset mid-transfer: pending write/unpack abandoned, FIFO contents discarded.
//  Address phase accepted when HSEL && HREADY && HTRANS[1]; captures HWRITE, HADDR[3:0], HSIZE.
//  Register map: 0x0 DATA (write pushes bytes; read returns 0); 0x4 STATUS (read only, writes ignored).
//  STATUS: [0]=empty, [1]=full, [15:8]=level zero-extended, rest 0. Read is zero-wait;
//   HRDATA driven in data phase from current level, 0 outside a read data phase.
//  Byte lane: lane = big_endian ? ~HADDR[1:0] : HADDR[1:0]; byte = HWDATA[8*lane +: 8].
//  DATA write (any size unless macro below): pushes one lane byte. Room = level<DEPTH, or a pop
//   in the same cycle. No room -> state WR_WAIT, HREADYOUT=0 until room; push in first cycle with room,
//   HREADYOUT=1 that cycle. HWDATA latched on first data-phase cycle.
//  States: IDLE, WR_WAIT, UNPACK. IDLE->WR_WAIT (byte push, no room); WR_WAIT->IDLE (pushed);
//   IDLE->UNPACK (word unpack, macro only); UNPACK->IDLE after 4th byte pushed.
//  FIFO: pop on out_valid&&out_ready; simultaneous push+pop keeps level; push+pop when full allowed;
//   pointers wrap modulo DEPTH; level never exceeds DEPTH or drops below 0.
//  out_byte/out_valid reflect head with no added latency after push: pushed byte visible next cycle.
// CONFIGURATION
//  MFP_AHB_BYTE_STREAM_WORD_UNPACK_EN defined: DATA write with HSIZE_4 enters UNPACK; pushes 4 bytes,
//   one per cycle when room, order [7:0],[15:8],[23:16],[31:24] (little) or reversed (big_endian=1);
//   HREADYOUT=0 until the cycle of the 4th push. HSIZE_1/HSIZE_2 behave as lane push.
//  Undefined: no UNPACK state; HSIZE_4 writes push only the addressed lane byte.
// TESTING
//  1 reset, then STATUS read -> HRDATA=0x0000_0001, out_valid=0, HREADYOUT=1.
//  2 HSIZE_1 writes 0x0,0x1,0x2,0x3 with HWDATA=0x44332211, big_endian=0 -> out bytes 11,22,33,44 in order.
//  3 out_ready=0, 17 byte writes (DEPTH 16) -> 17th stalls HREADYOUT=0; one pop -> accepted same cycle, level 16.
//  4 full FIFO, simultaneous push+pop every cycle for 32 cycles -> level stays 16, no data loss, order kept.
//  5 macro on, HSIZE_4 write 0xDDCCBBAA: big_endian=0 -> AA,BB,CC,DD; big_endian=1 -> DD,CC,BB,AA; 3 wait states.
//  6 reset asserted during UNPACK after 2 bytes -> next cycle level 0, out_valid 0, HREADYOUT 1, state IDLE.

Source files
------------

// File: rtl/mfp_ahb_lite_byte_stream_sink.sv
// AHB-lite slave that turns CPU stores into a byte stream drained through out_byte/out_valid/out_ready.
// Define MFP_AHB_BYTE_STREAM_WORD_UNPACK_EN to split HSIZE_4 DATA writes into four pushed bytes.
//   state   | meaning
//   IDLE    | no write pending; DATA write data phase pushes its lane byte directly
//   WR_WAIT | lane byte held in hold_q, waiting for FIFO room
//   UNPACK  | word held in hold_q, pushing bytes cnt_q..3 (macro builds only)
module mfp_ahb_lite_byte_stream_sink #(
   parameter int FIFO_DEPTH_LOG2 = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        big_endian,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic [2:0]  HSIZE,
   input  logic        HWRITE,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [7:0]  out_byte,
   output logic        out_valid,
   input  logic        out_ready
);
   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

   typedef enum logic [1:0] {IDLE = 2'd0, WR_WAIT = 2'd1, UNPACK = 2'd2} state_t;

   state_t                     state_q, state_d;
   logic                       ap_act_q;
   logic                       ap_write_q;
   logic [3:0]                 ap_addr_q;
   logic [31:0]                hold_q, hold_d;
   logic [7:0]                 mem_q [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_DEPTH_LOG2:0]   level_q;
   logic                       empty, full, pop, room, push, hready, dp_data_wr;
   logic [7:0]                 push_byte, level8;
   logic [1:0]                 lane, sel;
   logic                       unused_haddr;

   assign unused_haddr = ^HADDR[31:4];

`ifdef MFP_AHB_BYTE_STREAM_WORD_UNPACK_EN
   logic       ap_word_q;
   logic [1:0] cnt_q, cnt_d;
`else
   logic       unused_hsize;
   assign unused_hsize = ^HSIZE;
`endif

   always_comb begin
      empty      = (level_q == '0);
      full       = level_q[FIFO_DEPTH_LOG2];
      pop        = !empty && out_ready;
      // a pop in the same cycle frees the slot the push needs, even when full
      room       = !full || pop;
      dp_data_wr = ap_act_q && ap_write_q && (ap_addr_q[3:2] == 2'b00);
      lane       = big_endian ? ~ap_addr_q[1:0] : ap_addr_q[1:0];
      sel        = lane;
      push       = 1'b0;
      push_byte  = 8'h00;
      hready     = 1'b1;
      state_d    = state_q;
      hold_d     = hold_q;
`ifdef MFP_AHB_BYTE_STREAM_WORD_UNPACK_EN
      cnt_d      = cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (dp_data_wr) begin
               hold_d = HWDATA;
`ifdef MFP_AHB_BYTE_STREAM_WORD_UNPACK_EN
               if (ap_word_q) begin
                  sel     = big_endian ? 2'd3 : 2'd0;
                  push    = room;
                  cnt_d   = room ? 2'd1 : 2'd0;
                  state_d = UNPACK;
                  hready  = 1'b0;
               end else
`endif
               begin
                  push = room;
                  if (!room) begin
                     state_d = WR_WAIT;
                     hready  = 1'b0;
                  end
               end
               push_byte = HWDATA[{sel, 3'b000} +: 8];
            end
         end
         WR_WAIT: begin
            push_byte = hold_q[{sel, 3'b000} +: 8];
            push      = room;
            if (room) state_d = IDLE;
            else      hready  = 1'b0;
         end
`ifdef MFP_AHB_BYTE_STREAM_WORD_UNPACK_EN
         UNPACK: begin
            sel       = big_endian ? ~cnt_q : cnt_q;
            push_byte = hold_q[{sel, 3'b000} +: 8];
            push      = room;
            if (room) cnt_d = cnt_q + 2'd1;
            if (room && (cnt_q == 2'd3)) state_d = IDLE;
            else                         hready  = 1'b0;
         end
`endif
         default: state_d = IDLE;
      endcase

      level8                    = '0;
      level8[FIFO_DEPTH_LOG2:0] = level_q;
      HRDATA = 32'h0;
      if (ap_act_q && !ap_write_q && (ap_addr_q[3:2] == 2'b01))
         HRDATA = {16'h0, level8, 6'h0, full, empty};
      HREADYOUT = hready;
      HRESP     = 1'b0;
      out_valid = !empty;
      out_byte  = empty ? 8'h00 : mem_q[rd_ptr_q];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         ap_act_q   <= 1'b0;
         ap_write_q <= 1'b0;
         ap_addr_q  <= 4'h0;
         hold_q     <= 32'h0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
`ifdef MFP_AHB_BYTE_STREAM_WORD_UNPACK_EN
         ap_word_q  <= 1'b0;
         cnt_q      <= 2'd0;
`endif
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
`ifdef MFP_AHB_BYTE_STREAM_WORD_UNPACK_EN
         cnt_q   <= cnt_d;
`endif
         if (HREADY) begin
            ap_act_q   <= HSEL && HTRANS[1];
            ap_write_q <= HWRITE;
            ap_addr_q  <= HADDR[3:0];
`ifdef MFP_AHB_BYTE_STREAM_WORD_UNPACK_EN
            ap_word_q  <= (HSIZE == 3'b010);
`endif
         end
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (push && !pop)      level_q <= level_q + 1'b1;
         else if (pop && !push) level_q <= level_q - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= push_byte;
   end
endmodule

// File: tb/tb_mfp_ahb_lite_byte_stream_sink.sv
// Bench for mfp_ahb_lite_byte_stream_sink: queue-based model of the byte FIFO and pending write bytes,
// compared against the DUT every cycle, plus literal expectations for the directed scenarios.
`timescale 1ns/1ps
module tb_mfp_ahb_lite_byte_stream_sink;
   localparam int DEPTH = 16;

   logic        clock, reset, big_endian, HSEL, HWRITE, HREADY, out_ready;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic        HREADYOUT, HRESP, out_valid;
   logic [7:0]  out_byte;

   mfp_ahb_lite_byte_stream_sink #(.FIFO_DEPTH_LOG2(4)) dut (
      .clock(clock), .reset(reset), .big_endian(big_endian), .HSEL(HSEL), .HADDR(HADDR),
      .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
      .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .out_byte(out_byte),
      .out_valid(out_valid), .out_ready(out_ready));

   assign HREADY = HREADYOUT;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int          errors = 0, checks = 0, waits = 0, rdy_mode = 0;
   logic [7:0]  fifo_m[$], pend_m[$], obs[$];
   bit          dp_active = 0, dp_status = 0, accepted = 0;
   logic [31:0] a_data = 0, last_hrdata = 0;
   logic        last_valid = 0, last_hready = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cycle();
      bit pop, room, hr, acc;
      int ln;
      logic [31:0] hd;
      if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      pop  = (fifo_m.size() > 0) && out_ready;
      room = (fifo_m.size() < DEPTH) || pop;
      hr   = (pend_m.size() == 0) || (pend_m.size() == 1 && room);
      if (!reset) begin
         hd = 32'h0;
         if (dp_status)
            hd = {16'h0, 8'(fifo_m.size()), 6'h0, fifo_m.size() == DEPTH, fifo_m.size() == 0};
         chk("hreadyout", HREADYOUT, hr);
         chk("out_valid", out_valid, fifo_m.size() > 0);
         chk("out_byte", out_byte, fifo_m.size() > 0 ? fifo_m[0] : 8'h00);
         chk("hrdata", HRDATA, hd);
         chk("hresp", HRESP, 0);
         if (HREADYOUT === 1'b0) waits++;
         if (out_valid && out_ready) obs.push_back(out_byte);
         last_hrdata = HRDATA;
         last_valid  = out_valid;
         last_hready = HREADYOUT;
      end
      acc = !reset && HSEL && HTRANS[1] && hr;
      @(posedge clock);
      if (reset) begin
         fifo_m.delete(); pend_m.delete(); dp_active = 0; dp_status = 0;
      end else begin
         if (pop) void'(fifo_m.pop_front());
         if (pend_m.size() > 0 && room) fifo_m.push_back(pend_m.pop_front());
         if (dp_active && hr) begin dp_active = 0; dp_status = 0; end
         if (acc) begin
            accepted  = 1;
            dp_active = 1;
            dp_status = !HWRITE && (HADDR[3:2] == 2'b01);
            if (HWRITE && HADDR[3:2] == 2'b00) begin
`ifdef MFP_AHB_BYTE_STREAM_WORD_UNPACK_EN
               if (HSIZE == 3'b010) begin
                  for (int k = 0; k < 4; k++) pend_m.push_back(a_data[8*(big_endian ? 3-k : k) +: 8]);
               end else
`endif
               begin
                  ln = big_endian ? 3 - int'(HADDR[1:0]) : int'(HADDR[1:0]);
                  pend_m.push_back(a_data[8*ln +: 8]);
               end
            end
         end
      end
      #1;
      if (acc) HWDATA = a_data;
   endtask

   task automatic issue(bit w, logic [3:0] a, logic [2:0] sz, logic [31:0] d);
      logic [31:0] r;
      r = $urandom();
      HSEL = 1; HTRANS = 2'b10; HWRITE = w; HADDR = {r[31:4], a}; HSIZE = sz;
      a_data = d; accepted = 0;
      for (int n = 0; n < 100 && !accepted; n++) cycle();
      chk("accept_timeout", accepted, 1);
      HSEL = 0; HTRANS = 2'b00;
   endtask

   task automatic finish_bus();
      HSEL = 0; HTRANS = 2'b00;
      for (int n = 0; n < 200 && dp_active; n++) cycle();
      chk("drain_timeout", dp_active, 0);
   endtask

   task automatic chk_obs(string nm, int n, logic [31:0] e);
      chk({nm, "_count"}, obs.size(), n);
      for (int i = 0; i < n; i++)
         chk(nm, i < obs.size() ? {24'h0, obs[i]} : 32'hFFFF_FFFF, {24'h0, e[8*i +: 8]});
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1; big_endian = 0; HSEL = 0; HWRITE = 0; HADDR = 0; HTRANS = 0; HSIZE = 0;
      HWDATA = 0; out_ready = 0;
      cycle(); cycle();
      reset = 0;

      // 1: status after reset
      issue(0, 4'h4, 3'b010, 0); finish_bus();
      chk("t1_status", last_hrdata, 32'h0000_0001);
      chk("t1_valid", last_valid, 0);
      chk("t1_hready", last_hready, 1);

      // 2: byte writes to each lane, little endian
      rdy_mode = 0; out_ready = 0;
      for (int i = 0; i < 4; i++) issue(1, 4'(i), 3'b000, 32'h4433_2211);
      finish_bus();
      obs.delete(); out_ready = 1;
      repeat (6) cycle();
      out_ready = 0;
      chk_obs("t2_order", 4, 32'h4433_2211);

      // 3: 17th byte stalls on a full FIFO until one pop
      for (int i = 0; i < 17; i++) issue(1, 4'h0, 3'b000, $urandom());
      waits = 0;
      repeat (3) cycle();
      out_ready = 1; cycle(); out_ready = 0;
      chk("t3_waits", waits, 3);
      chk("t3_done", dp_active, 0);
      issue(0, 4'h4, 3'b000, 0); finish_bus();
      chk("t3_status", last_hrdata, 32'h0000_1002);

      // 4: full FIFO, push and pop every cycle
      waits = 0;
      issue(1, 4'h0, 3'b000, $urandom());
      rdy_mode = 1; out_ready = 1;
      for (int i = 0; i < 31; i++) issue(1, 4'($urandom_range(0, 3)), 3'b000, $urandom());
      finish_bus();
      rdy_mode = 0; out_ready = 0;
      chk("t4_waits", waits, 0);
      issue(0, 4'h4, 3'b000, 0); finish_bus();
      chk("t4_status", last_hrdata, 32'h0000_1002);
      out_ready = 1; repeat (20) cycle(); out_ready = 0;

      // 5: word write in both byte orders
      for (int be = 0; be < 2; be++) begin
         big_endian = 1'(be); rdy_mode = 1; out_ready = 1;
         obs.delete(); waits = 0;
         issue(1, 4'h0, 3'b010, 32'hDDCC_BBAA); finish_bus();
         repeat (6) cycle();
`ifdef MFP_AHB_BYTE_STREAM_WORD_UNPACK_EN
         chk("t5_waits", waits, 3);
         chk_obs(be ? "t5_big" : "t5_little", 4, be ? 32'hAABB_CCDD : 32'hDDCC_BBAA);
`else
         chk("t5_waits", waits, 0);
         chk_obs(be ? "t5_big" : "t5_little", 1, be ? 32'h0000_00DD : 32'h0000_00AA);
`endif
      end
      big_endian = 0; rdy_mode = 0; out_ready = 0;

      // 6: reset in the middle of a word write
      issue(1, 4'h0, 3'b010, $urandom());
      cycle(); cycle();
      reset = 1; cycle(); reset = 0;
      cycle();
      chk("t6_valid", last_valid, 0);
      chk("t6_hready", last_hready, 1);
      issue(0, 4'h4, 3'b000, 0); finish_bus();
      chk("t6_status", last_hrdata, 32'h0000_0001);

      // random traffic
      for (int g = 0; g < 25; g++) begin
         big_endian = 1'($urandom_range(0, 1));
         rdy_mode = $urandom_range(1, 2);
         out_ready = 1;
         for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 9))
               0: issue(0, 4'h4 | 4'($urandom_range(0, 3)), 3'b010, 0);
               1: issue(0, 4'($urandom_range(0, 3)), 3'b000, 0);
               2: issue(1, 4'h4, 3'b010, $urandom());
               3: issue(1, 4'h8 | 4'($urandom_range(0, 7)), 3'($urandom_range(0, 2)), $urandom());
               4: begin
                  HSEL = 0; HTRANS = 2'b10; HWRITE = 1; HADDR = 0; HSIZE = 0;
                  cycle();
                  HTRANS = 2'b00;
               end
               default: issue(1, 4'($urandom_range(0, 3)), 3'($urandom_range(0, 2)), $urandom());
            endcase
         end
         finish_bus();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
